mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline: EX/MEM pipeline register, word-addressed data memory, store-data forwarding mux, and MEM/WB pipeline register.
- Consumes the 2-bit store-forward select produced by the forward unit. That unit compares wb_write_reg (RegLw) with mem_store_reg (RegSw), using wb_reg_write and wb_mem_to_reg.
- Produces the WB-stage write-back value and the register fields the forward unit needs.

Parameters:
- DEPTH, 256, data memory size in 32-bit words; must be a power of two.
- ADDR_W, 8, log2(DEPTH); word index bits taken from the byte address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  freeze both pipeline registers; inhibit memory write.
- flush  in  1  load a bubble into EX/MEM.
- ex_reg_write  in  1  EX instr writes the register file.
- ex_mem_to_reg  in  1  EX instr is a load.
- ex_mem_write  in  1  EX instr is a store.
- ex_alu_result  in  32  byte address or ALU result.
- ex_store_data  in  32  rt value read in ID/EX.
- ex_write_reg  in  5  destination register.
- ex_store_reg  in  5  rt number of the store.
- forwardF  in  2  store-data select: 00 = ex-latched data, 01 = wb_read_data, 10 = wb_alu_result, 11 = treated as 00.
- mem_store_reg  out  5  EX/MEM rt field, to the forward unit.
- mem_mem_write  out  1  EX/MEM store flag.
- wb_reg_write  out  1  MEM/WB write enable.
- wb_mem_to_reg  out  1  MEM/WB load flag.
- wb_write_reg  out  5  MEM/WB destination.
- wb_alu_result  out  32  MEM/WB ALU result.
- wb_read_data  out  32  MEM/WB loaded word.
- wb_write_data  out  32  wb_mem_to_reg ? wb_read_data : wb_alu_result (combinational).
- wb_addr_err  out  1  misaligned access reached WB.

Behaviour:
- Reset:
  - When rst_n = 0 at a rising edge, every EX/MEM and MEM/WB field clears to 0, so all outputs are 0.
  - No memory write occurs that cycle, even if EX/MEM held a store (reset wins).
  - Memory contents are not cleared by reset.
- Priority per edge: reset > stall > flush > normal.
- stall = 1:
  - EX/MEM and MEM/WB hold their values; memory write is suppressed.
  - forwardF keeps selecting from the frozen MEM/WB, so the forwarded value stays stable.
  - stall together with flush means hold; the flush is ignored.
- flush = 1 (no stall): EX/MEM control bits (reg_write, mem_to_reg, mem_write) load 0; data fields load anyway. MEM/WB advances normally.
- Normal operation:
  - EX/MEM captures all ex_* inputs.
  - MEM/WB captures the EX/MEM controls, write_reg, alu_result, and the memory read word.
- Addressing:
  - Word index = alu_result[ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH.
  - If alu_result[1:0] != 0 on a load or store, the access is suppressed (no write; read_data captured as 0) and wb_addr_err = 1 in the following WB cycle.
- Store data = forwardF mux of EX/MEM store_data / wb_read_data / wb_alu_result, selected in the same cycle.
  - The memory write happens at the rising edge ending the MEM cycle when mem_mem_write = 1, stall = 0 and the address is aligned.
- Loads: combinational memory read in MEM, registered into wb_read_data. Latency from the load entering EX/MEM to wb_write_data valid is 1 cycle.
- Load and store at the same address cannot coexist in MEM (one instruction per stage), so read-during-write is undefined and not required.

Test Plan:
- Reset: drive a store into EX/MEM, then rst_n = 0 for 1 edge → all outputs 0; a later load of that address returns the prior content (here 0 after initial write of 0).
- Plain store/load:
  - sw 0xDEADBEEF to byte addr 0x10, then lw 0x10, write_reg = 8.
  - Required: wb_read_data = 0xDEADBEEF and wb_write_data = 0xDEADBEEF one cycle after the lw is in MEM; wb_write_reg = 8.
- Load-to-store forward:
  - lw r5 ← [0x20] (holds 0x12345678), then sw r5 → 0x24 with stale ex_store_data = 0, forwardF = 01.
  - Required: [0x24] reads back 0x12345678.
- ALU-to-store forward: add r6 = 0xA5A5 (wb_alu_result), then sw r6 → 0x28 with forwardF = 10 → [0x28] = 0x0000A5A5. With forwardF = 11 → stale data stored.
- Stall/flush:
  - stall for 3 cycles with a sw in MEM: exactly one write occurs, all outputs constant.
  - flush with a sw in EX: no memory write, and wb_reg_write = 0 next cycle.
- Boundary:
  - sw to byte addr 0x401 → no write, wb_addr_err = 1 for one cycle.
  - sw to byte addr 0x400 with DEPTH = 256 → wraps to word 0; a load of 0x0 returns the stored value.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake/bus bundle for the MEM stage: EX-side inputs, forward-unit select,
// and the EX/MEM and MEM/WB fields exposed to the forward unit and WB.
interface mem_stage_if;
  logic        stall;
  logic        flush;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_mem_write;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic [4:0]  ex_store_reg;
  logic [1:0]  forwardF;
  logic [4:0]  mem_store_reg;
  logic        mem_mem_write;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_data;
  logic [31:0] wb_write_data;
  logic        wb_addr_err;

  modport master (
    output stall, flush, ex_reg_write, ex_mem_to_reg, ex_mem_write,
           ex_alu_result, ex_store_data, ex_write_reg, ex_store_reg, forwardF,
    input  mem_store_reg, mem_mem_write, wb_reg_write, wb_mem_to_reg,
           wb_write_reg, wb_alu_result, wb_read_data, wb_write_data, wb_addr_err
  );

  modport slave (
    input  stall, flush, ex_reg_write, ex_mem_to_reg, ex_mem_write,
           ex_alu_result, ex_store_data, ex_write_reg, ex_store_reg, forwardF,
    output mem_store_reg, mem_mem_write, wb_reg_write, wb_mem_to_reg,
           wb_write_reg, wb_alu_result, wb_read_data, wb_write_data, wb_addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, word-addressed data RAM with store-data
// forwarding, MEM/WB register and the write-back select.
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic [4:0]  store_reg;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic        addr_err;
  } memwb_t;

  exmem_t em, em_nxt;
  memwb_t wb, wb_nxt;

  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              aligned;
  logic [31:0]       st_data;
  logic [31:0]       rd_word;

  assign idx     = em.alu_result[ADDR_W+1:2];
  assign aligned = (em.alu_result[1:0] == 2'b00);

  // Forwarded sources come from the MEM/WB register, so they stay frozen under stall.
  always_comb begin
    st_data = em.store_data;
    case (bus.forwardF)
      2'b01:   st_data = wb.read_data;
      2'b10:   st_data = wb.alu_result;
      default: st_data = em.store_data;
    endcase
  end

  // Only aligned loads return memory; everything else captures zero.
  assign rd_word = (em.mem_to_reg && aligned) ? ram[idx] : 32'h0;

  always_comb begin
    em_nxt = '{reg_write:  bus.ex_reg_write,
               mem_to_reg: bus.ex_mem_to_reg,
               mem_write:  bus.ex_mem_write,
               alu_result: bus.ex_alu_result,
               store_data: bus.ex_store_data,
               write_reg:  bus.ex_write_reg,
               store_reg:  bus.ex_store_reg};
    if (bus.flush) begin
      em_nxt.reg_write  = 1'b0;
      em_nxt.mem_to_reg = 1'b0;
      em_nxt.mem_write  = 1'b0;
    end
  end

  always_comb begin
    wb_nxt = '{reg_write:  em.reg_write,
               mem_to_reg: em.mem_to_reg,
               write_reg:  em.write_reg,
               alu_result: em.alu_result,
               read_data:  rd_word,
               addr_err:   (em.mem_to_reg || em.mem_write) && !aligned};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      em <= '0;
      wb <= '0;
    end else if (!bus.stall) begin
      em <= em_nxt;
      wb <= wb_nxt;
    end
  end

  // RAM contents survive reset; a reset edge still blocks the pending store.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.stall && em.mem_write && aligned)
      ram[idx] <= st_data;
  end

  assign bus.mem_store_reg = em.store_reg;
  assign bus.mem_mem_write = em.mem_write;
  assign bus.wb_reg_write  = wb.reg_write;
  assign bus.wb_mem_to_reg = wb.mem_to_reg;
  assign bus.wb_write_reg  = wb.write_reg;
  assign bus.wb_alu_result = wb.alu_result;
  assign bus.wb_read_data  = wb.read_data;
  assign bus.wb_write_data = wb.mem_to_reg ? wb.read_data : wb.alu_result;
  assign bus.wb_addr_err   = wb.addr_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan scenarios plus random instruction
// streams, all outputs compared every cycle against an instruction-level model.
module tb_mem_stage;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage #(.DEPTH(DEPTH), .ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef enum int {NOP, ALU, LW, SW} kind_e;

  // Model: one instruction record per stage plus a flat word memory.
  typedef struct {
    bit        rw, m2r, mw;
    bit [31:0] alu, sd;
    bit [4:0]  wr, sr;
  } ins_t;
  typedef struct {
    bit        rw, m2r, err;
    bit [4:0]  wr;
    bit [31:0] alu, rd;
  } wbrec_t;

  ins_t      m_em;
  wbrec_t    m_wb;
  bit [31:0] ref_mem [DEPTH];

  function automatic int unsigned widx(bit [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(kind_e k, bit [31:0] a, bit [31:0] d, bit [4:0] rd, bit [4:0] rt);
    bus.ex_reg_write  = (k == ALU) || (k == LW);
    bus.ex_mem_to_reg = (k == LW);
    bus.ex_mem_write  = (k == SW);
    bus.ex_alu_result = (k == ALU) ? d : a;
    bus.ex_store_data = d;
    bus.ex_write_reg  = rd;
    bus.ex_store_reg  = rt;
  endtask

  task automatic model_edge();
    bit        al;
    bit [31:0] val;
    wbrec_t    n;
    if (!rst_n) begin
      m_em = '{default: 0};
      m_wb = '{default: 0};
    end else if (!bus.stall) begin
      al = (m_em.alu % 4) == 0;
      case (bus.forwardF)
        2'd1:    val = m_wb.rd;
        2'd2:    val = m_wb.alu;
        default: val = m_em.sd;
      endcase
      n.rw  = m_em.rw;
      n.m2r = m_em.m2r;
      n.wr  = m_em.wr;
      n.alu = m_em.alu;
      n.rd  = (m_em.m2r && al) ? ref_mem[widx(m_em.alu)] : 32'h0;
      n.err = (m_em.m2r || m_em.mw) && !al;
      if (m_em.mw && al) ref_mem[widx(m_em.alu)] = val;
      m_wb = n;
      m_em.rw  = bus.ex_reg_write  && !bus.flush;
      m_em.m2r = bus.ex_mem_to_reg && !bus.flush;
      m_em.mw  = bus.ex_mem_write  && !bus.flush;
      m_em.alu = bus.ex_alu_result;
      m_em.sd  = bus.ex_store_data;
      m_em.wr  = bus.ex_write_reg;
      m_em.sr  = bus.ex_store_reg;
    end
  endtask

  task automatic check_all();
    chk("mem_store_reg", {27'h0, bus.mem_store_reg}, {27'h0, m_em.sr});
    chk("mem_mem_write", {31'h0, bus.mem_mem_write}, {31'h0, m_em.mw});
    chk("wb_reg_write",  {31'h0, bus.wb_reg_write},  {31'h0, m_wb.rw});
    chk("wb_mem_to_reg", {31'h0, bus.wb_mem_to_reg}, {31'h0, m_wb.m2r});
    chk("wb_write_reg",  {27'h0, bus.wb_write_reg},  {27'h0, m_wb.wr});
    chk("wb_alu_result", bus.wb_alu_result, m_wb.alu);
    chk("wb_read_data",  bus.wb_read_data,  m_wb.rd);
    chk("wb_write_data", bus.wb_write_data, m_wb.m2r ? m_wb.rd : m_wb.alu);
    chk("wb_addr_err",   {31'h0, bus.wb_addr_err},   {31'h0, m_wb.err});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic op(kind_e k, bit [31:0] a, bit [31:0] d, bit [4:0] rd, bit [4:0] rt);
    set_in(k, a, d, rd, rt);
    tick();
  endtask

  task automatic load_chk(string tag, bit [31:0] a, bit [31:0] exp);
    op(LW, a, 0, 5'd9, 0);
    op(NOP, 0, 0, 0, 0);
    chk(tag, bus.wb_write_data, exp);
  endtask

  initial begin
    bus.stall = 0; bus.flush = 0; bus.forwardF = 0;
    set_in(NOP, 0, 0, 0, 0);
    m_em = '{default: 0};
    m_wb = '{default: 0};

    // Reset state
    tick(); tick();
    chk("rst_write_data", bus.wb_write_data, 32'h0);
    chk("rst_mem_write", {31'h0, bus.mem_mem_write}, 32'h0);
    rst_n = 1;

    // Fill the whole memory so every later read is known to the model
    for (int i = 0; i < DEPTH; i++) op(SW, i * 4, $urandom, 0, 5'(i));
    op(NOP, 0, 0, 0, 0); op(NOP, 0, 0, 0, 0);

    // Reset wins over a pending store
    op(SW, 32'h40, 32'h0, 0, 1); op(NOP, 0, 0, 0, 0); op(NOP, 0, 0, 0, 0);
    op(SW, 32'h40, 32'h77, 0, 1);
    rst_n = 0;
    op(NOP, 0, 0, 0, 0);
    chk("rst2_mem_write", {31'h0, bus.mem_mem_write}, 32'h0);
    chk("rst2_store_reg", {27'h0, bus.mem_store_reg}, 32'h0);
    chk("rst2_write_data", bus.wb_write_data, 32'h0);
    rst_n = 1;
    load_chk("rst_no_write", 32'h40, 32'h0);

    // Plain store/load
    op(SW, 32'h10, 32'hDEADBEEF, 0, 2);
    op(LW, 32'h10, 0, 5'd8, 0);
    op(NOP, 0, 0, 0, 0);
    chk("lw_read_data", bus.wb_read_data, 32'hDEADBEEF);
    chk("lw_write_data", bus.wb_write_data, 32'hDEADBEEF);
    chk("lw_write_reg", {27'h0, bus.wb_write_reg}, 32'd8);

    // Load-to-store forward
    op(SW, 32'h20, 32'h12345678, 0, 1); op(NOP, 0, 0, 0, 0);
    op(LW, 32'h20, 0, 5'd5, 0);
    op(SW, 32'h24, 32'h0, 0, 5'd5);
    bus.forwardF = 2'b01;
    op(NOP, 0, 0, 0, 0);
    bus.forwardF = 2'b00;
    load_chk("fwd_load", 32'h24, 32'h12345678);

    // ALU-to-store forward, then select 11 falls back to latched data
    op(ALU, 0, 32'hA5A5, 5'd6, 0);
    op(SW, 32'h28, 32'h1111, 0, 5'd6);
    bus.forwardF = 2'b10;
    op(NOP, 0, 0, 0, 0);
    bus.forwardF = 2'b00;
    load_chk("fwd_alu", 32'h28, 32'h0000A5A5);
    op(ALU, 0, 32'hA5A5, 5'd6, 0);
    op(SW, 32'h2C, 32'h2222, 0, 5'd6);
    bus.forwardF = 2'b11;
    op(NOP, 0, 0, 0, 0);
    bus.forwardF = 2'b00;
    load_chk("fwd_11_stale", 32'h2C, 32'h2222);

    // Stall for 3 cycles with a store in MEM
    op(SW, 32'h30, 32'h0A0A, 0, 1); op(NOP, 0, 0, 0, 0);
    op(ALU, 0, 32'h99, 5'd4, 0);
    op(SW, 32'h30, 32'hB0B0, 0, 5'd3);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      op(ALU, 0, 32'hFFFF0000 + i, 5'd12, 0);
      chk("stall_mem_write", {31'h0, bus.mem_mem_write}, 32'h1);
      chk("stall_wb_alu", bus.wb_alu_result, 32'h99);
    end
    bus.stall = 0;
    op(NOP, 0, 0, 0, 0);
    load_chk("stall_store", 32'h30, 32'hB0B0);

    // Flush: store and ALU op become bubbles
    op(SW, 32'h34, 32'hC0C0, 0, 1); op(NOP, 0, 0, 0, 0);
    bus.flush = 1;
    op(SW, 32'h34, 32'hD0D0, 0, 1);
    chk("flush_mem_write", {31'h0, bus.mem_mem_write}, 32'h0);
    op(ALU, 0, 32'h55, 5'd7, 0);
    bus.flush = 0;
    op(NOP, 0, 0, 0, 0);
    chk("flush_reg_write", {31'h0, bus.wb_reg_write}, 32'h0);
    chk("flush_alu_data", bus.wb_alu_result, 32'h55);
    load_chk("flush_no_write", 32'h34, 32'hC0C0);

    // Misaligned store and address wrap
    op(SW, 32'h0, 32'hE0E0, 0, 1); op(NOP, 0, 0, 0, 0);
    op(SW, 32'h401, 32'h1234, 0, 1);
    op(NOP, 0, 0, 0, 0);
    chk("misalign_err", {31'h0, bus.wb_addr_err}, 32'h1);
    op(NOP, 0, 0, 0, 0);
    chk("misalign_err_clr", {31'h0, bus.wb_addr_err}, 32'h0);
    load_chk("misalign_no_write", 32'h0, 32'hE0E0);
    op(SW, 32'h400, 32'hF0F0, 0, 1); op(NOP, 0, 0, 0, 0);
    load_chk("wrap_store", 32'h0, 32'hF0F0);

    // Random instruction stream
    for (int i = 0; i < 600; i++) begin
      kind_e     k;
      bit [31:0] a;
      k = kind_e'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      bus.stall    = ($urandom_range(0, 9) == 0);
      bus.flush    = ($urandom_range(0, 9) == 0);
      bus.forwardF = 2'($urandom_range(0, 3));
      op(k, a, $urandom, 5'($urandom), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
